vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, the vertical equivalents in lines.
REQ-006 SHALL have parameters HS_POL, VS_POL, 0, 0, sync pulse level during the sync interval (0 = active-low).
REQ-007 SHALL have parameter CLK_DIV, 2, clk cycles per pixel, legal 1..4.
REQ-008 SHALL have parameter CW, 10, coordinate width; it must hold H_TOTAL-1 and V_TOTAL-1.
REQ-009 SHALL have port clk, input, 1, system clock.
REQ-010 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-011 SHALL have port en, input, 1, timing run enable.
REQ-012 SHALL have ports h_sync and v_sync, output, 1 each, sync pulses at HS_POL/VS_POL.
REQ-013 SHALL have ports blank_n and sync_n, output, 1 each; blank_n high in the active area, sync_n tied 1.
REQ-014 SHALL have ports posx and posy, output, CW each, active-area coordinates.
REQ-015 SHALL have port pix_en, output, 1, one-clk pixel strobe.
REQ-016 SHALL have ports line_start and frame_start, output, 1 each, one-clk pulses.
REQ-017 SHALL have port frame_cnt, output, 8, frame counter.

Function
REQ-018 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; region order within a line/frame: active, FP, sync, BP.
REQ-019 Prescaler counts 0..CLK_DIV-1 while en=1; pix_en=1 for the clk where it equals CLK_DIV-1; with CLK_DIV=1, pix_en = en.
REQ-020 hcount advances only on pix_en and wraps H_TOTAL-1 -> 0; vcount advances when hcount wraps and wraps V_TOTAL-1 -> 0.
REQ-021 frame_cnt increments, modulo 256, when both counters wrap together.
REQ-022 While en=0, the prescaler, counters and all outputs hold; pulse outputs are forced to 0.
REQ-023 All outputs are registered, update on the clk edge after the counter update, and are mutually aligned.
REQ-024 blank_n=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-025 posx=hcount and posy=vcount when blank_n=1, else 0.
REQ-026 h_sync=HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-027 v_sync uses the same rule with the V_ parameters and VS_POL; it changes only when the hcount wrap occurs.
REQ-028 line_start pulses on the pix_en where hcount becomes 0; frame_start pulses where both counters become 0.

Reset
REQ-029 On rst=1 at a clk edge: prescaler, hcount, vcount and frame_cnt are 0; outputs h_sync=~HS_POL, v_sync=~VS_POL, blank_n=0, posx=posy=0, pix_en=line_start=frame_start=0, sync_n=1.
REQ-030 rst overrides en; mid-frame reset restarts at pixel (0,0) with no partial sync pulse.
REQ-031 First pix_en after reset release occurs CLK_DIV clks after the first clk with en=1; frame_start is asserted with it.

Configuration
REQ-032 Macro VGA_TIMING_LOOKAHEAD_EN, when defined, adds outputs nxt_x, nxt_y (CW each) and nxt_valid (1), giving the coordinate and active flag of the next pixel.
REQ-033 nxt_* lead posx/posy/blank_n by exactly one pixel period, including across line and frame wrap, so a 1-pixel-latency memory can be pre-read; reset values are 0.
REQ-034 Without the macro these ports and their logic are absent and all other behaviour is identical.

Verification
REQ-035 Defaults: rst 2 clks, en=1 -> pix_en every 2nd clk; line_start period 1600 clks; frame_start period 840000 clks; frame_cnt=1 after the first full frame.
REQ-036 Defaults: h_sync low for exactly 96 pixels starting at hcount 656; v_sync low for exactly 2 lines starting at vcount 490.
REQ-037 Defaults: blank_n high for 640 pixels per line on lines 0..479 only; posx sequence 0..639; posy=479 on the last active line.
REQ-038 Mid-frame: en=0 for 50 clks at hcount 300 -> outputs frozen; resume continues at hcount 300; rst pulse at vcount 200 -> next output is (0,0) with frame_start.
REQ-039 CLK_DIV=1, HS_POL=VS_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V 4/1/1/1 -> line period 14 clks, frame period 98 clks, sync pulses high.
REQ-040 With VGA_TIMING_LOOKAHEAD_EN: nxt_x equals posx one pixel later; at hcount 799, vcount 524, nxt_valid=1 and nxt_x=nxt_y=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA-style raster timing generator with a clk-to-pixel
// prescaler, sync pulses, blanking, active-area coordinates and
// line/frame strobes. Defining VGA_TIMING_LOOKAHEAD_EN adds the
// nxt_x / nxt_y / nxt_valid ports, which give the next pixel's coordinate
// and active flag one pixel period early.
//
// hcount/vcount hold the pixel that the next pixel strobe emits. On a
// strobe, every output register is loaded from the decode of that pixel,
// and the counters step to the following pixel in the same edge. The
// outputs therefore always describe one pixel together, and the first
// strobe after reset emits pixel (0,0) with frame_start.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          blank_n,
  output logic          sync_n,
  output logic [CW-1:0] posx,
  output logic [CW-1:0] posy,
  output logic          pix_en,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CW-1:0] nxt_x,
  output logic [CW-1:0] nxt_y,
  output logic          nxt_valid
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] presc;
  logic [CW-1:0] hcount, vcount;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          strobe, h_wrap, v_wrap, active;
  logic          started;   // a pixel has been emitted since reset

  assign strobe = en && (presc == P_LAST);
  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);
  assign h_nxt  = h_wrap ? '0 : hcount + 1'b1;
  assign v_nxt  = h_wrap ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
  assign active = (hcount < H_ACT) && (vcount < V_ACT);

  // Composite sync is not generated; the pin stays inactive.
  assign sync_n = 1'b1;

  // Prescaler: counts enabled clks, strobe on the last count.
  always_ff @(posedge clk) begin
    if (rst)     presc <= '0;
    else if (en) presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
  end

  // Raster position: step one pixel per strobe, wrap line then frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (strobe) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
    end
  end

  // Output registers: decode the emitted pixel; pulses only on a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      started     <= 1'b0;
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      blank_n     <= 1'b0;
      posx        <= '0;
      posy        <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_en      <= strobe;
      line_start  <= strobe && (hcount == '0);
      frame_start <= strobe && (hcount == '0) && (vcount == '0);
      if (strobe) begin
        started <= 1'b1;
        blank_n <= active;
        posx    <= active ? hcount : '0;
        posy    <= active ? vcount : '0;
        h_sync  <= (hcount >= HS_BEG && hcount < HS_END) ? HS_POL : ~HS_POL;
        v_sync  <= (vcount >= VS_BEG && vcount < VS_END) ? VS_POL : ~VS_POL;
        // Count a frame when pixel (0,0) is re-entered after a wrap, so the
        // new count appears together with that frame's frame_start.
        if (started && hcount == '0 && vcount == '0)
          frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic nxt_act;
  assign nxt_act = (h_nxt < H_ACT) && (v_nxt < V_ACT);

  // Lookahead: decode of the pixel the following strobe will emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_x     <= '0;
      nxt_y     <= '0;
      nxt_valid <= 1'b0;
    end else if (strobe) begin
      nxt_x     <= nxt_act ? h_nxt : '0;
      nxt_y     <= nxt_act ? v_nxt : '0;
      nxt_valid <= nxt_act;
    end
  end
`endif

endmodule
